i2c_reg_sequencer: RTL and testbench
====================================

Name: i2c_reg_sequencer

Overview:
- Transaction-level controller in front of the byte-level I2C master.
- Converts one register-write or register-read request into the full command sequence and drives the master's cmd/din/wr_i2c interface. The master's command codes are START=000, WR=001, RD=010, STOP=011, RESTART=100.
- Reports read data, ACK errors and timeouts back to the requester.
- Used to program the camera sensor registers at boot.

Parameters:
- GAP_CYCLES, 1000, idle clocks enforced after STOP before the next request is accepted (bus free time).
- TIMEOUT_CYCLES, 2000000, maximum clocks spent waiting for the master in any single command step before aborting.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_rw  in  1  0 = register write, 1 = register read
- req_dev_addr  in  7  7-bit device address
- req_reg_addr  in  8  register address
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle pulse: transaction finished
- rsp_rdata  out  8  read data, valid with rsp_valid
- rsp_err  out  2  00 ok, 01 NACK on device address, 10 NACK on register/data byte, 11 timeout
- busy  out  1  transaction or gap in progress
- m_cmd  out  3  command to master
- m_din  out  8  byte to master
- m_wr_i2c  out  1  one-cycle command strobe to master
- m_ready  in  1  master ready for a command
- m_done_tick  in  1  master byte complete
- m_ack  in  1  ACK bit sampled by master (0 = ACK)
- m_dout  in  8  master read byte

Behaviour:
- Reset is asynchronous, active-high, clock is clk. On reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, m_wr_i2c=0, m_cmd=000, m_din=0, all counters 0.
- Reset mid-transaction returns to IDLE immediately; no STOP is issued.
- Accept: in IDLE, req_ready=1. On req_valid&req_ready, latch all req fields, set step=0, go ISSUE. req_ready=0 from the next cycle until the return to IDLE.
- Write step list: START; WR {dev,0}; WR reg; WR wdata; STOP.
- Read step list: START; WR {dev,0}; WR reg; RESTART; WR {dev,1}; RD with m_din=8'hFF (din[0]=1 makes the master NACK the single byte); STOP.
- For non-WR/RD steps, m_din=0.
- States:
  - IDLE: accept requests as above.
  - ISSUE: wait for m_ready=1. Then drive m_cmd/m_din for the current step and pulse m_wr_i2c for exactly 1 cycle; go WAIT_LO.
  - WAIT_LO: wait for m_ready=0, which acknowledges the master consumed the command.
  - WAIT_HI: wait for m_ready=1. Data sampling and step advance are described below.
  - GAP: count GAP_CYCLES clocks, then go IDLE.
- Data sampling in WAIT_HI, for WR/RD steps:
  - On m_done_tick, capture m_ack, and m_dout for RD.
  - m_ready rising after a WR/RD step is accepted only if m_done_tick was seen.
- Step advance on m_ready=1 in WAIT_HI:
  - If it was STOP: go GAP.
  - Else if a captured WR ack=1: error abort.
  - Else step+1 and go ISSUE.
  - m_cmd/m_din hold their last values between strobes.
- Error abort: record rsp_err (01 for a NACK on either device-address byte, 10 for reg/wdata), jump to the STOP step. The STOP is still issued, then GAP.
- rsp_valid pulses 1 cycle on the GAP entry cycle, with rsp_err and rsp_rdata stable from then until the next accept. rsp_rdata=0 for writes and for errored reads.
- Timeout:
  - A per-step counter is cleared on each m_wr_i2c and counts in WAIT_LO/WAIT_HI (and in ISSUE).
  - On reaching TIMEOUT_CYCLES: rsp_err=11, rsp_valid pulse, go IDLE directly with no STOP.
  - Timeout has priority over a same-cycle m_ready.
- busy=1 in every state except IDLE.
- req_valid while busy is ignored and is not queued.

Test Plan:
1. Write dev=7'h21, reg=8'h12, data=8'h80, with a slave model ACKing every byte. The master must see strobes in order START, WR 8'h42, WR 8'h12, WR 8'h80, STOP. Then rsp_valid=1 once with rsp_err=00, followed by busy for GAP_CYCLES.
2. Read dev=7'h21, reg=8'h0A, slave returns 8'h76. Strobes must be START, WR 8'h42, WR 8'h0A, RESTART, WR 8'h43, RD with din 8'hFF, STOP. Then rsp_rdata=8'h76 and rsp_err=00.
3. Slave NACKs the first address byte on a write. Only START, WR 8'h42, STOP are issued; rsp_err=01; no register byte is sent.
4. Slave NACKs the data byte (8'h80). STOP is issued; rsp_err=10.
5. m_ready held 0 after START, with TIMEOUT_CYCLES=50. Exactly 50 clocks later rsp_valid=1 with rsp_err=11, then IDLE and req_ready=1.
6. Assert reset mid-byte on step 3. All outputs reach their reset values asynchronously; a following request completes correctly. A second req_valid during busy is dropped, with exactly one rsp_valid produced.

Source files
------------

// File: rtl/i2c_reg_sequencer.sv
// Register-level front end for the byte-level I2C master: expands one register
// write or read request into START/WR/RESTART/RD/STOP commands and reports status.
module i2c_reg_sequencer #(
  parameter int GAP_CYCLES     = 1000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev_addr,
  input  logic [7:0] req_reg_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic       busy,
  output logic [2:0] m_cmd,
  output logic [7:0] m_din,
  output logic       m_wr_i2c,
  input  logic       m_ready,
  input  logic       m_done_tick,
  input  logic       m_ack,
  input  logic [7:0] m_dout
);

  localparam logic [2:0] CMD_START   = 3'b000;
  localparam logic [2:0] CMD_WR      = 3'b001;
  localparam logic [2:0] CMD_RD      = 3'b010;
  localparam logic [2:0] CMD_STOP    = 3'b011;
  localparam logic [2:0] CMD_RESTART = 3'b100;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT_LO = 3'd2;
  localparam logic [2:0] S_WAIT_HI = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ADDR    = 2'b01;
  localparam logic [1:0] ERR_DATA    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic [2:0]    step_q, step_d;
  logic          rw_q, rw_d;
  logic [6:0]    dev_q, dev_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rd_byte_q, rd_byte_d;
  logic          done_seen_q, done_seen_d;
  logic          ack_q, ack_d;
  logic [1:0]    err_pend_q, err_pend_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [2:0]    cmd_q, cmd_d;
  logic [7:0]    din_q, din_d;
  logic          wr_q, wr_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_rdata_q, rsp_rdata_d;
  logic [1:0]    rsp_err_q, rsp_err_d;

  logic [2:0] cur_cmd;
  logic [7:0] cur_din;
  logic       cur_is_addr;
  logic       cur_is_data;
  logic [2:0] stop_step;
  logic       seen_now;
  logic       ack_now;

  // Command table for the current step; the STOP step is the last entry of each list.
  always_comb begin
    cur_cmd     = CMD_STOP;
    cur_din     = 8'h00;
    cur_is_addr = 1'b0;
    if (!rw_q) begin
      case (step_q)
        3'd0:    cur_cmd = CMD_START;
        3'd1:    begin cur_cmd = CMD_WR; cur_din = {dev_q, 1'b0}; cur_is_addr = 1'b1; end
        3'd2:    begin cur_cmd = CMD_WR; cur_din = reg_q; end
        3'd3:    begin cur_cmd = CMD_WR; cur_din = wdata_q; end
        default: cur_cmd = CMD_STOP;
      endcase
    end else begin
      case (step_q)
        3'd0:    cur_cmd = CMD_START;
        3'd1:    begin cur_cmd = CMD_WR; cur_din = {dev_q, 1'b0}; cur_is_addr = 1'b1; end
        3'd2:    begin cur_cmd = CMD_WR; cur_din = reg_q; end
        3'd3:    cur_cmd = CMD_RESTART;
        3'd4:    begin cur_cmd = CMD_WR; cur_din = {dev_q, 1'b1}; cur_is_addr = 1'b1; end
        3'd5:    begin cur_cmd = CMD_RD; cur_din = 8'hFF; end
        default: cur_cmd = CMD_STOP;
      endcase
    end
  end

  assign stop_step   = rw_q ? 3'd6 : 3'd4;
  assign cur_is_data = (cur_cmd == CMD_WR) || (cur_cmd == CMD_RD);
  assign seen_now    = done_seen_q | m_done_tick;
  assign ack_now     = m_done_tick ? m_ack : ack_q;

  always_comb begin
    // NOTE: every _d starts as its _q (strobes as 0) so no branch can leave a latch behind.
    state_d     = state_q;
    step_d      = step_q;
    rw_d        = rw_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    rd_byte_d   = rd_byte_q;
    done_seen_d = done_seen_q;
    ack_d       = ack_q;
    err_pend_d  = err_pend_q;
    tmo_d       = tmo_q;
    gap_d       = gap_q;
    cmd_d       = cmd_q;
    din_d       = din_q;
    wr_d        = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rw_d        = req_rw;
          dev_d       = req_dev_addr;
          reg_d       = req_reg_addr;
          wdata_d     = req_wdata;
          step_d      = 3'd0;
          tmo_d       = '0;
          err_pend_d  = ERR_OK;
          rd_byte_d   = 8'h00;
          rsp_err_d   = ERR_OK;
          rsp_rdata_d = 8'h00;
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE, S_WAIT_LO, S_WAIT_HI: begin
        // A stuck step wins over anything the master does in the same cycle.
        if (tmo_q == TMO_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_TIMEOUT;
          rsp_rdata_d = 8'h00;
          state_d     = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
          if (state_q != S_ISSUE && m_done_tick) begin
            done_seen_d = 1'b1;
            ack_d       = m_ack;
            if (cur_cmd == CMD_RD) rd_byte_d = m_dout;
          end
          case (state_q)
            S_ISSUE: begin
              if (m_ready) begin
                cmd_d       = cur_cmd;
                din_d       = cur_din;
                wr_d        = 1'b1;
                tmo_d       = '0;
                done_seen_d = 1'b0;
                ack_d       = 1'b0;
                state_d     = S_WAIT_LO;
              end
            end
            S_WAIT_LO: begin
              if (!m_ready) state_d = S_WAIT_HI;
            end
            default: begin
              if (m_ready) begin
                if (step_q == stop_step) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = err_pend_q;
                  rsp_rdata_d = (rw_q && err_pend_q == ERR_OK) ? rd_byte_q : 8'h00;
                  gap_d       = '0;
                  state_d     = S_GAP;
                end else if (cur_is_data && !seen_now) begin
                  state_d = S_WAIT_HI;
                end else if (cur_cmd == CMD_WR && ack_now) begin
                  err_pend_d = cur_is_addr ? ERR_ADDR : ERR_DATA;
                  step_d     = stop_step;
                  state_d    = S_ISSUE;
                end else begin
                  step_d  = step_q + 3'd1;
                  state_d = S_ISSUE;
                end
              end
            end
          endcase
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + GW'(1);
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      step_q      <= 3'd0;
      rw_q        <= 1'b0;
      dev_q       <= 7'h00;
      reg_q       <= 8'h00;
      wdata_q     <= 8'h00;
      rd_byte_q   <= 8'h00;
      done_seen_q <= 1'b0;
      ack_q       <= 1'b0;
      err_pend_q  <= ERR_OK;
      tmo_q       <= '0;
      gap_q       <= '0;
      cmd_q       <= CMD_START;
      din_q       <= 8'h00;
      wr_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= ERR_OK;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      rw_q        <= rw_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      rd_byte_q   <= rd_byte_d;
      done_seen_q <= done_seen_d;
      ack_q       <= ack_d;
      err_pend_q  <= err_pend_d;
      tmo_q       <= tmo_d;
      gap_q       <= gap_d;
      cmd_q       <= cmd_d;
      din_q       <= din_d;
      wr_q        <= wr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign m_cmd     = cmd_q;
  assign m_din     = din_q;
  assign m_wr_i2c  = wr_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: a behavioural I2C master/slave answers the command
// strobes; expected strobes and responses are queued when each request is driven.
module tb_i2c_reg_sequencer;

  localparam int GAP = 20;
  localparam int TMO = 50;
  localparam int LAT = 3;

  localparam logic [2:0] C_START   = 3'b000;
  localparam logic [2:0] C_WR      = 3'b001;
  localparam logic [2:0] C_RD      = 3'b010;
  localparam logic [2:0] C_STOP    = 3'b011;
  localparam logic [2:0] C_RESTART = 3'b100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rw = 1'b0;
  logic [6:0] req_dev_addr = 7'h00;
  logic [7:0] req_reg_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic       busy;
  logic [2:0] m_cmd;
  logic [7:0] m_din;
  logic       m_wr_i2c;
  logic       m_ready = 1'b1;
  logic       m_done_tick = 1'b0;
  logic       m_ack = 1'b0;
  logic [7:0] m_dout = 8'h00;

  i2c_reg_sequencer #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .m_cmd(m_cmd), .m_din(m_din), .m_wr_i2c(m_wr_i2c),
    .m_ready(m_ready), .m_done_tick(m_done_tick), .m_ack(m_ack), .m_dout(m_dout)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [10:0] exp_strobe_q[$];
  logic [9:0]  exp_rsp_q[$];
  int          strobe_idx = 0;
  int          nack_idx = -1;
  int          unexpected_strobes = 0;
  int          unexpected_rsps = 0;
  int          rsp_count = 0;
  int unsigned strobe_cyc = 0;
  bit          hang_start = 1'b0;
  logic [7:0]  slave_rdata = 8'h00;

  // Master + slave model, changing its outputs only on the falling edge.
  int          mst_state = 0;
  int          mst_lat = 0;
  logic [2:0]  mst_cmd = 3'b000;
  logic        mst_ack = 1'b0;
  logic [10:0] strobe_e;
  always @(negedge clk) begin
    if (reset) begin
      mst_state   = 0;
      m_ready     = 1'b1;
      m_done_tick = 1'b0;
    end else begin
      case (mst_state)
        0: begin
          m_done_tick = 1'b0;
          if (m_wr_i2c) begin
            strobe_cyc = cyc;
            if (exp_strobe_q.size() == 0) unexpected_strobes++;
            else begin
              strobe_e = exp_strobe_q.pop_front();
              check($sformatf("strobe%0d", strobe_idx), 32'({m_cmd, m_din}), 32'(strobe_e));
            end
            mst_cmd   = m_cmd;
            mst_ack   = (m_cmd == C_RD) ? 1'b1 : (strobe_idx == nack_idx);
            strobe_idx++;
            m_ready   = 1'b0;
            mst_lat   = LAT;
            mst_state = 1;
          end
        end
        1: begin
          if (!(hang_start && mst_cmd == C_START)) begin
            if (mst_lat > 0) mst_lat--;
            else if (mst_cmd == C_WR || mst_cmd == C_RD) begin
              m_done_tick = 1'b1;
              m_ack       = mst_ack;
              m_dout      = (mst_cmd == C_RD) ? slave_rdata : 8'h00;
              mst_state   = 2;
            end else begin
              m_ready   = 1'b1;
              mst_state = 0;
            end
          end
        end
        default: begin
          m_done_tick = 1'b0;
          m_ready     = 1'b1;
          mst_state   = 0;
        end
      endcase
    end
  end

  logic [9:0] rsp_e;
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      rsp_count++;
      if (exp_rsp_q.size() == 0) unexpected_rsps++;
      else begin
        rsp_e = exp_rsp_q.pop_front();
        check("rsp_err", 32'(rsp_err), 32'(rsp_e[9:8]));
        check("rsp_rdata", 32'(rsp_rdata), 32'(rsp_e[7:0]));
      end
    end
  end

  task automatic push_seq(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                          input logic [7:0] wd, input int nack);
    logic [10:0] full [6];
    int n;
    full[0] = {C_START, 8'h00};
    full[1] = {C_WR, dev, 1'b0};
    full[2] = {C_WR, ra};
    if (!rw) begin
      full[3] = {C_WR, wd};
      full[4] = '0;
      full[5] = '0;
      n = 4;
    end else begin
      full[3] = {C_RESTART, 8'h00};
      full[4] = {C_WR, dev, 1'b1};
      full[5] = {C_RD, 8'hFF};
      n = 6;
    end
    for (int i = 0; i < n; i++) begin
      exp_strobe_q.push_back(full[i]);
      if (i == nack) break;
    end
    exp_strobe_q.push_back({C_STOP, 8'h00});
    strobe_idx = 0;
    nack_idx   = nack;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!req_ready && n < 500) begin @(negedge clk); n++; end
    check({tag, "_idle"}, 32'(req_ready), 32'd1);
  endtask

  task automatic drive_req(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                           input logic [7:0] wd);
    req_valid = 1'b1; req_rw = rw; req_dev_addr = dev; req_reg_addr = ra; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 500) begin @(negedge clk); n++; end
    check({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    check({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_m_wr_i2c"},  32'(m_wr_i2c),  32'd0);
    check({tag, "_m_cmd"},     32'(m_cmd),     32'd0);
    check({tag, "_m_din"},     32'(m_din),     32'd0);
  endtask

  initial begin
    int n;
    int base;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // 1: register write, all bytes ACKed, then the bus-free gap
    push_seq(1'b0, 7'h21, 8'h12, 8'h80, -1);
    exp_rsp_q.push_back({2'b00, 8'h00});
    wait_idle("t1");
    drive_req(1'b0, 7'h21, 8'h12, 8'h80);
    wait_rsp("t1");
    n = 1;
    @(negedge clk);
    check("t1_rsp_pulse", 32'(rsp_valid), 32'd0);
    while (busy && n < 200) begin n++; @(negedge clk); end
    check("t1_gap_len", 32'(n), 32'(GAP));
    check("t1_strobes_left", 32'(exp_strobe_q.size()), 32'd0);

    // 2: register read returning 0x76
    slave_rdata = 8'h76;
    push_seq(1'b1, 7'h21, 8'h0A, 8'h00, -1);
    exp_rsp_q.push_back({2'b00, 8'h76});
    wait_idle("t2");
    drive_req(1'b1, 7'h21, 8'h0A, 8'h00);
    wait_rsp("t2");
    wait_idle("t2_end");
    check("t2_strobes_left", 32'(exp_strobe_q.size()), 32'd0);

    // 3: NACK on the device address byte
    push_seq(1'b0, 7'h21, 8'h12, 8'h80, 1);
    exp_rsp_q.push_back({2'b01, 8'h00});
    wait_idle("t3");
    drive_req(1'b0, 7'h21, 8'h12, 8'h80);
    wait_rsp("t3");
    wait_idle("t3_end");
    check("t3_strobes_left", 32'(exp_strobe_q.size()), 32'd0);

    // 4: NACK on the data byte
    push_seq(1'b0, 7'h21, 8'h12, 8'h80, 3);
    exp_rsp_q.push_back({2'b10, 8'h00});
    wait_idle("t4");
    drive_req(1'b0, 7'h21, 8'h12, 8'h80);
    wait_rsp("t4");
    wait_idle("t4_end");
    check("t4_strobes_left", 32'(exp_strobe_q.size()), 32'd0);

    // 5: master never comes back after START; no STOP may follow
    hang_start = 1'b1;
    strobe_idx = 0;
    nack_idx   = -1;
    exp_strobe_q.push_back({C_START, 8'h00});
    exp_rsp_q.push_back({2'b11, 8'h00});
    wait_idle("t5");
    drive_req(1'b0, 7'h21, 8'h12, 8'h80);
    wait_rsp("t5");
    check("t5_latency", cyc - strobe_cyc, 32'(TMO));
    check("t5_req_ready", 32'(req_ready), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    hang_start = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_strobes_left", 32'(exp_strobe_q.size()), 32'd0);

    // 6: asynchronous reset while the register byte is on the bus
    push_seq(1'b0, 7'h21, 8'h12, 8'h80, -1);
    wait_idle("t6");
    drive_req(1'b0, 7'h21, 8'h12, 8'h80);
    n = 0;
    while (strobe_idx < 3 && n < 200) begin @(negedge clk); n++; end
    check("t6_reach_step", 32'(strobe_idx), 32'd3);
    check("t6_pre_din", 32'(m_din), 32'h12);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("t6_async");
    exp_strobe_q.delete();
    exp_rsp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    base = rsp_count;
    push_seq(1'b0, 7'h21, 8'h34, 8'h56, -1);
    exp_rsp_q.push_back({2'b00, 8'h00});
    wait_idle("t6b");
    drive_req(1'b0, 7'h21, 8'h34, 8'h56);
    repeat (3) @(negedge clk);
    drive_req(1'b1, 7'h10, 8'h99, 8'h00);
    wait_rsp("t6b");
    wait_idle("t6b_end");
    repeat (30) @(negedge clk);
    check("t6_one_rsp", 32'(rsp_count - base), 32'd1);
    check("t6_strobes_left", 32'(exp_strobe_q.size()), 32'd0);
    check("unexpected_strobes", 32'(unexpected_strobes), 32'd0);
    check("unexpected_rsps", 32'(unexpected_rsps), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, %0d tests run, %0d failed", tests, failed);
    $fatal(1);
  end

endmodule
